// File: rtl/parity_pkg.sv
// Shared types and constants for the parity transmit chain.
package parity_pkg;

  localparam int DATA_W_DEF       = 4;
  localparam int CLKS_PER_BIT_DEF = 4;
  // start + data + parity + stop
  localparam int FRAME_BITS       = DATA_W_DEF + 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: one-cycle tick in the last cycle of every serial bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Held at zero while cleared so the first bit of a frame is full length.
  assign tick = !clr && (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1, wrapping at each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start, data LSB first, parity, stop.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] m,
  input  logic              par,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] sh_nxt;
  logic              par_q;
  logic [BW-1:0]     bit_cnt;
  logic              tx_q;
  logic              tick;
  logic              accept;

  assign accept = in_valid && in_ready;
  assign sh_nxt = shreg >> 1;
  assign tx     = tx_q;

  // Timer stays cleared in IDLE; every later state entry lands on a wrap.
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake/status outputs.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = START;
      end
      START:  if (tick) state_d = DATA;
      DATA:   if (tick && (bit_cnt == LAST_BIT)) state_d = PARITY;
      PARITY: if (tick) state_d = STOP;
      STOP: begin
        if (tick) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: tx is loaded with the value of the bit about to start, so the
  // line changes exactly at state/bit boundaries straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            shreg   <= m;
            par_q   <= par;
            bit_cnt <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: if (tick) tx_q <= shreg[0];
        DATA: begin
          if (tick) begin
            shreg   <= sh_nxt;
            bit_cnt <= bit_cnt + 1'b1;
            tx_q    <= (bit_cnt == LAST_BIT) ? par_q : sh_nxt[0];
          end
        end
        PARITY: if (tick) tx_q <= 1'b1;
        default: tx_q <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: scoreboarded frames on a default instance,
// plus a CLKS_PER_BIT=1 instance for the minimum bit period.
module tb_parity_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] m;
  logic       par, in_valid;
  logic       in_ready, tx, busy, frame_done;

  logic [3:0] m1;
  logic       par1, in_valid1;
  logic       in_ready1, tx1, busy1, frame_done1;

  parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .m(m), .par(par), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .m(m1), .par(par1), .in_valid(in_valid1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1), .frame_done(frame_done1)
  );

  typedef struct packed {
    logic [3:0] m;
    logic       p;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   frames_seen = 0;
  int   aborted = 0;

  always @(posedge clk) cyc++;

  // Expected line waveform for one default frame, cycles 1..28.
  function automatic logic [28:1] exp_wave(exp_t e);
    logic [28:1] w;
    int idx;
    for (int kk = 1; kk <= 28; kk++) begin
      idx = (kk - 1) / 4;
      if (idx == 0)      w[kk] = 1'b0;
      else if (idx <= 4) w[kk] = e.m[idx-1];
      else if (idx == 5) w[kk] = e.p;
      else               w[kk] = 1'b1;
    end
    return w;
  endfunction

  // Frame monitor for the default instance.
  bit          in_frame = 0;
  bit          fd_early;
  int          k;
  logic [28:1] obs;
  always @(negedge clk) begin
    exp_t e;
    logic [28:1] ew;
    if (in_frame && k == 28) begin
      tests++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL ready_after_done: in_ready=%b busy=%b, want 1 0", in_ready, busy);
      end
      in_frame = 0;
    end else if (in_frame && !busy) begin
      aborted++;
      if (q.size() > 0) void'(q.pop_front());
      in_frame = 0;
    end else if (in_frame) begin
      k++;
      obs[k] = tx;
      if (k < 28 && frame_done) fd_early = 1;
      if (k == 28) begin
        tests++;
        if (frame_done !== 1'b1) begin
          fails++;
          $display("FAIL frame_done_last: frame_done=%b at cycle 28, want 1", frame_done);
        end
        tests++;
        if (fd_early) begin
          fails++;
          $display("FAIL frame_done_early: pulse seen before cycle 28, want none");
        end
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: frame seen with empty scoreboard");
        end else begin
          e  = q.pop_front();
          ew = exp_wave(e);
          if (obs !== ew) begin
            fails++;
            $display("FAIL frame_wave m=%b: got %b, want %b", e.m, obs, ew);
          end
          tests++;
          if (obs[21] !== ^e.m) begin
            fails++;
            $display("FAIL parity_bit m=%b: got %b, want %b", e.m, obs[21], ^e.m);
          end
        end
        frames_seen++;
      end
    end else if (busy) begin
      in_frame = 1;
      k        = 1;
      obs      = '0;
      obs[1]   = tx;
      fd_early = frame_done;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  // Present a word and hold it until accepted; returns the accept cycle.
  task automatic send(input logic [3:0] mv, input logic pv, output int acc);
    int b = 0;
    m = mv; par = pv; in_valid = 1'b1;
    while (!in_ready && b < 60) begin @(negedge clk); b++; end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout m=%b: in_ready=%b, want 1", mv, in_ready);
    end
    acc = cyc;
    q.push_back('{m: mv, p: pv});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    int b = 0;
    while (frames_seen < target && b < 600) begin @(negedge clk); b++; end
    repeat (2) @(negedge clk);
    tests++;
    if (frames_seen < target) begin
      fails++;
      $display("FAIL %s_timeout: frames=%0d, want %0d", name, frames_seen, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m = '0; par = 1'b0; in_valid = 1'b0;
    m1 = '0; par1 = 1'b0; in_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if ({tx, in_ready, busy, frame_done} !== 4'b1100) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: tx/rdy/busy/done=%b, want 1100", i,
                 {tx, in_ready, busy, frame_done});
      end
    end
    tests++;
    if ({tx1, in_ready1, busy1, frame_done1} !== 4'b1100) begin
      fails++;
      $display("FAIL reset_idle_cpb1: got %b, want 1100", {tx1, in_ready1, busy1, frame_done1});
    end
  endtask

  task automatic test_single_frame();
    int f0 = frames_seen;
    int a;
    send(4'b1011, 1'b1, a);
    wait_frames(f0 + 1, "single");
  endtask

  task automatic test_back_to_back();
    int f0 = frames_seen;
    int acc[16];
    for (int v = 0; v < 16; v++) begin
      logic [3:0] mv;
      mv = 4'(v);
      m = mv; par = ^mv; in_valid = 1'b1;
      begin
        int b = 0;
        while (!in_ready && b < 60) begin @(negedge clk); b++; end
      end
      acc[v] = cyc;
      q.push_back('{m: mv, p: ^mv});
      @(negedge clk);
      if (v > 0) begin
        tests++;
        if (acc[v] - acc[v-1] !== 29) begin
          fails++;
          $display("FAIL accept_spacing v=%0d: got %0d cycles, want 29", v, acc[v] - acc[v-1]);
        end
      end
    end
    in_valid = 1'b0;
    wait_frames(f0 + 16, "sweep");
  endtask

  task automatic test_busy_ignore();
    int f0 = frames_seen;
    int a;
    int b = 0;
    send(4'b1001, 1'b0, a);
    for (int i = 0; i < 20; i++) begin
      m = 4'b0110; par = 1'b0; in_valid = i[0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    while (!frame_done && b < 60) begin @(negedge clk); b++; end
    // Pulse in_valid in the frame_done cycle; must not be taken.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (frames_seen !== f0 + 1) begin
      fails++;
      $display("FAIL busy_frames: got %0d frames, want %0d", frames_seen - f0, 1);
    end
    tests++;
    if (busy !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL busy_no_extra: busy=%b pending=%0d, want 0 0", busy, q.size());
    end
  endtask

  task automatic test_async_reset();
    int f0 = frames_seen;
    int a0 = aborted;
    int a;
    send(4'b0101, 1'b0, a);
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({tx, busy, in_ready} !== 3'b101) begin
      fails++;
      $display("FAIL async_reset: tx/busy/rdy=%b, want 101", {tx, busy, in_ready});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (aborted !== a0 + 1) begin
      fails++;
      $display("FAIL reset_abort: aborted=%0d, want %0d", aborted - a0, 1);
    end
    send(4'b0001, 1'b1, a);
    wait_frames(f0 + 1, "post_reset");
  endtask

  task automatic test_min_period();
    logic [6:0] txv, fdv;
    @(negedge clk);
    m1 = 4'b1111; par1 = 1'b0; in_valid1 = 1'b1;
    tests++;
    if (in_ready1 !== 1'b1) begin
      fails++;
      $display("FAIL cpb1_ready: in_ready=%b, want 1", in_ready1);
    end
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      txv[i] = tx1;
      fdv[i] = frame_done1;
      @(negedge clk);
    end
    tests++;
    if (txv !== 7'b1011110) begin
      fails++;
      $display("FAIL cpb1_wave: got %b, want %b", txv, 7'b1011110);
    end
    tests++;
    if (fdv !== 7'b1000000) begin
      fails++;
      $display("FAIL cpb1_done: got %b, want %b", fdv, 7'b1000000);
    end
    tests++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      fails++;
      $display("FAIL cpb1_idle: in_ready=%b busy=%b, want 1 0", in_ready1, busy1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_busy_ignore();
    test_async_reset();
    test_min_period();
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
